// File: rtl/ball_motion_engine.sv
// Multi-ball 3-D fixed-point motion engine: one ball per clock is advanced during a frame sweep,
// with ground bounce, bounce limit and settle/auto-clear, plus per-ball screen coordinates.
module ball_motion_engine #(
   parameter int N_BALLS       = 4,
   parameter int ID_W          = (N_BALLS > 1) ? $clog2(N_BALLS) : 1,
   parameter int POS_W         = 16,
   parameter int OUT_W         = 13,
   parameter int OUT_SHIFT     = 2,
   parameter int X_ACC         = 1,
   parameter int Y_ACC         = 0,
   parameter int Z_ACC         = 3,
   parameter int BOUNCE_SHIFT  = 1,
   parameter int BOUNCE_MIN    = 4,
   parameter int MAX_BOUNCES   = 2,
   parameter int SETTLE_FRAMES = 60
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_refresh,
   input  logic                       i_launch,
   input  logic [ID_W-1:0]            i_launch_id,
   input  logic signed [POS_W-1:0]    i_vx,
   input  logic signed [POS_W-1:0]    i_vy,
   input  logic signed [POS_W-1:0]    i_vz,
   input  logic [N_BALLS-1:0]         i_en_collision,
   input  logic [N_BALLS-1:0]         i_collision_done,
   output logic [N_BALLS*OUT_W-1:0]   o_x_pos,
   output logic [N_BALLS*OUT_W-1:0]   o_y_pos,
   output logic [N_BALLS-1:0]         o_z_neg,
   output logic [N_BALLS-1:0]         o_active,
   output logic                       o_busy,
   output logic                       o_frame_done,
   output logic                       o_overrun
);

   localparam int BcW  = (MAX_BOUNCES > 0) ? $clog2(MAX_BOUNCES + 1) : 1;
   localparam int SetW = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
   localparam logic signed [POS_W-1:0] XAcc   = POS_W'(X_ACC);
   localparam logic signed [POS_W-1:0] YAcc   = POS_W'(Y_ACC);
   localparam logic signed [POS_W-1:0] ZAcc   = POS_W'(Z_ACC);
   localparam logic [POS_W-1:0]        BMin   = POS_W'(BOUNCE_MIN);
   localparam logic [BcW-1:0]          BcMax  = BcW'(MAX_BOUNCES);
   localparam logic [SetW-1:0]         SetMax = SetW'(SETTLE_FRAMES);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
   typedef enum logic [1:0] {PhIdle, PhFlight, PhSettle} phase_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   idx_q, idx_d;
   logic              overrun_q, overrun_d;

   logic signed [POS_W-1:0] x_q [N_BALLS], y_q [N_BALLS], z_q [N_BALLS];
   logic signed [POS_W-1:0] vx_q [N_BALLS], vy_q [N_BALLS], vz_q [N_BALLS];
   logic signed [POS_W-1:0] x_d [N_BALLS], y_d [N_BALLS], z_d [N_BALLS];
   logic signed [POS_W-1:0] vx_d [N_BALLS], vy_d [N_BALLS], vz_d [N_BALLS];
   logic [BcW-1:0]          bcnt_q [N_BALLS], bcnt_d [N_BALLS];
   logic [SetW-1:0]         scnt_q [N_BALLS], scnt_d [N_BALLS];
   phase_e                  phase_q [N_BALLS], phase_d [N_BALLS];

   // Next state of the ball currently selected by the sweep
   logic signed [POS_W-1:0] u_x, u_y, u_z, u_vx, u_vy, u_vz, z_nxt, vz_nxt;
   logic [POS_W-1:0]        vz_abs;
   logic [BcW-1:0]          u_bcnt;
   logic [SetW-1:0]         u_scnt;
   phase_e                  u_phase;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      overrun_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (i_refresh) begin
               state_d = StRun;
               idx_d   = '0;
            end
         end
         StRun: begin
            overrun_d = i_refresh;
            if (idx_q == ID_W'(N_BALLS - 1)) state_d = StDone;
            else                             idx_d   = idx_q + ID_W'(1);
         end
         StDone: begin
            overrun_d = i_refresh;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      u_x     = x_q[idx_q];
      u_y     = y_q[idx_q];
      u_z     = z_q[idx_q];
      u_vx    = vx_q[idx_q];
      u_vy    = vy_q[idx_q];
      u_vz    = vz_q[idx_q];
      u_bcnt  = bcnt_q[idx_q];
      u_scnt  = scnt_q[idx_q];
      u_phase = phase_q[idx_q];
      z_nxt   = z_q[idx_q] + vz_q[idx_q];
      vz_nxt  = vz_q[idx_q] - ZAcc;
      vz_abs  = vz_q[idx_q][POS_W-1] ? -vz_q[idx_q] : vz_q[idx_q];
      unique case (phase_q[idx_q])
         PhFlight: begin
            u_x  = x_q[idx_q] + vx_q[idx_q];
            u_y  = y_q[idx_q] + vy_q[idx_q];
            u_vx = vx_q[idx_q] - XAcc;
            u_vy = vy_q[idx_q] - YAcc;
            if (!z_nxt[POS_W-1]) begin
               u_z  = z_nxt;
               u_vz = vz_nxt;
            end else if (bcnt_q[idx_q] < BcMax && vz_abs > BMin) begin
               u_z    = '0;
               u_vz   = vz_abs - (vz_abs >> BOUNCE_SHIFT);
               u_bcnt = bcnt_q[idx_q] + BcW'(1);
            end else begin
               // Landed: the sinking z stays visible, vz is kept as-is
               u_z     = z_nxt;
               u_phase = PhSettle;
               u_scnt  = '0;
            end
         end
         PhSettle: begin
            if (scnt_q[idx_q] < SetMax) begin
               u_scnt = scnt_q[idx_q] + SetW'(1);
            end else if (!i_en_collision[idx_q]) begin
               u_x = '0; u_y = '0; u_z = '0; u_vx = '0; u_vy = '0; u_vz = '0;
               u_bcnt = '0; u_scnt = '0; u_phase = PhIdle;
            end
         end
         default: ;
      endcase
   end

   // Per-slot priority: launch, then clear request, then sweep update
   always_comb begin
      for (int k = 0; k < N_BALLS; k++) begin
         x_d[k] = x_q[k]; y_d[k] = y_q[k]; z_d[k] = z_q[k];
         vx_d[k] = vx_q[k]; vy_d[k] = vy_q[k]; vz_d[k] = vz_q[k];
         bcnt_d[k] = bcnt_q[k]; scnt_d[k] = scnt_q[k]; phase_d[k] = phase_q[k];
         if (i_launch && i_launch_id == ID_W'(k)) begin
            x_d[k] = '0; y_d[k] = '0; z_d[k] = '0;
            vx_d[k] = i_vx; vy_d[k] = i_vy; vz_d[k] = i_vz;
            bcnt_d[k] = '0; scnt_d[k] = '0; phase_d[k] = PhFlight;
         end else if (i_collision_done[k]) begin
            x_d[k] = '0; y_d[k] = '0; z_d[k] = '0;
            vx_d[k] = '0; vy_d[k] = '0; vz_d[k] = '0;
            bcnt_d[k] = '0; scnt_d[k] = '0; phase_d[k] = PhIdle;
         end else if (state_q == StRun && idx_q == ID_W'(k)) begin
            x_d[k] = u_x; y_d[k] = u_y; z_d[k] = u_z;
            vx_d[k] = u_vx; vy_d[k] = u_vy; vz_d[k] = u_vz;
            bcnt_d[k] = u_bcnt; scnt_d[k] = u_scnt; phase_d[k] = u_phase;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         overrun_q <= 1'b0;
         for (int k = 0; k < N_BALLS; k++) begin
            x_q[k] <= '0; y_q[k] <= '0; z_q[k] <= '0;
            vx_q[k] <= '0; vy_q[k] <= '0; vz_q[k] <= '0;
            bcnt_q[k] <= '0; scnt_q[k] <= '0; phase_q[k] <= PhIdle;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         overrun_q <= overrun_d;
         for (int k = 0; k < N_BALLS; k++) begin
            x_q[k] <= x_d[k]; y_q[k] <= y_d[k]; z_q[k] <= z_d[k];
            vx_q[k] <= vx_d[k]; vy_q[k] <= vy_d[k]; vz_q[k] <= vz_d[k];
            bcnt_q[k] <= bcnt_d[k]; scnt_q[k] <= scnt_d[k]; phase_q[k] <= phase_d[k];
         end
      end
   end

   for (genvar k = 0; k < N_BALLS; k++) begin : g_out
      logic signed [POS_W-1:0] x_sh;
      logic signed [POS_W:0]   y_sum, y_sh;
      logic                    unused_sh;
      assign x_sh  = x_q[k] >>> OUT_SHIFT;
      // Half of z is added so height reads as an upward screen offset
      assign y_sum = {y_q[k][POS_W-1], y_q[k]}
                   + {{2{z_q[k][POS_W-1]}}, z_q[k][POS_W-1:1]};
      assign y_sh  = y_sum >>> OUT_SHIFT;
      assign o_x_pos[k*OUT_W +: OUT_W] = x_sh[OUT_W-1:0];
      assign o_y_pos[k*OUT_W +: OUT_W] = y_sh[OUT_W-1:0];
      assign o_z_neg[k]  = (phase_q[k] == PhSettle);
      assign o_active[k] = (phase_q[k] != PhIdle);
      assign unused_sh   = ^{x_sh[POS_W-1:OUT_W], y_sh[POS_W:OUT_W]};
   end

   assign o_busy       = (state_q != StIdle);
   assign o_frame_done = (state_q == StDone);
   assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Randomized and directed bench for ball_motion_engine, checked every cycle against a
// frame-level arithmetic model of the balls and the sweep timeline.
module tb_ball_motion_engine;
   localparam int N = 4, POS_W = 16, OUT_W = 13, OSH = 2;
   localparam int XA = 1, YA = 0, ZA = 3, BSH = 1, BMIN = 4, MAXB = 1, SETTLE = 60;

   logic                     i_clk = 1'b0;
   logic                     i_rst_n, i_refresh, i_launch;
   logic [1:0]               i_launch_id;
   logic signed [POS_W-1:0]  i_vx, i_vy, i_vz;
   logic [N-1:0]             i_en_collision, i_collision_done;
   logic [N*OUT_W-1:0]       o_x_pos, o_y_pos;
   logic [N-1:0]             o_z_neg, o_active;
   logic                     o_busy, o_frame_done, o_overrun;

   ball_motion_engine #(
      .N_BALLS(N), .POS_W(POS_W), .OUT_W(OUT_W), .OUT_SHIFT(OSH), .X_ACC(XA), .Y_ACC(YA),
      .Z_ACC(ZA), .BOUNCE_SHIFT(BSH), .BOUNCE_MIN(BMIN), .MAX_BOUNCES(MAXB),
      .SETTLE_FRAMES(SETTLE)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_refresh(i_refresh), .i_launch(i_launch),
      .i_launch_id(i_launch_id), .i_vx(i_vx), .i_vy(i_vy), .i_vz(i_vz),
      .i_en_collision(i_en_collision), .i_collision_done(i_collision_done),
      .o_x_pos(o_x_pos), .o_y_pos(o_y_pos), .o_z_neg(o_z_neg), .o_active(o_active),
      .o_busy(o_busy), .o_frame_done(o_frame_done), .o_overrun(o_overrun)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0, n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: balls as plain integers; phase 0 idle, 1 flight, 2 settled.
   // sweep = -1 when idle, k while ball k is being advanced, N for the done cycle.
   int mx[N], my[N], mz[N], mvx[N], mvy[N], mvz[N], mb[N], ms[N], mph[N];
   int sweep;
   bit m_ov;

   function automatic int w16(input int v);
      logic signed [15:0] t;
      t = v[15:0];
      return int'(t);
   endfunction

   task automatic m_clear(input int k);
      mx[k] = 0; my[k] = 0; mz[k] = 0; mvx[k] = 0; mvy[k] = 0; mvz[k] = 0;
      mb[k] = 0; ms[k] = 0; mph[k] = 0;
   endtask

   task automatic m_reset();
      for (int k = 0; k < N; k++) m_clear(k);
      sweep = -1;
      m_ov = 0;
   endtask

   task automatic m_frame(input int k);
      int zn, vzn, a;
      if (mph[k] == 1) begin
         zn  = w16(mz[k] + mvz[k]);
         vzn = w16(mvz[k] - ZA);
         mx[k] = w16(mx[k] + mvx[k]);
         my[k] = w16(my[k] + mvy[k]);
         mvx[k] = w16(mvx[k] - XA);
         mvy[k] = w16(mvy[k] - YA);
         a = (mvz[k] < 0) ? -mvz[k] : mvz[k];
         if (zn >= 0) begin
            mz[k] = zn; mvz[k] = vzn;
         end else if (mb[k] < MAXB && a > BMIN) begin
            mz[k] = 0; mvz[k] = w16(a - (a >> BSH)); mb[k]++;
         end else begin
            mz[k] = zn; mph[k] = 2; ms[k] = 0;
         end
      end else if (mph[k] == 2) begin
         if (ms[k] < SETTLE) ms[k]++;
         else if (!i_en_collision[k]) m_clear(k);
      end
   endtask

   task automatic m_step();
      bit ov_next;
      ov_next = i_refresh && (sweep >= 0);
      for (int k = 0; k < N; k++) begin
         if (i_launch && int'(i_launch_id) == k) begin
            mx[k] = 0; my[k] = 0; mz[k] = 0; mb[k] = 0; ms[k] = 0; mph[k] = 1;
            mvx[k] = int'(i_vx); mvy[k] = int'(i_vy); mvz[k] = int'(i_vz);
         end else if (i_collision_done[k]) begin
            m_clear(k);
         end else if (sweep == k) begin
            m_frame(k);
         end
      end
      if (sweep < 0) begin
         if (i_refresh) sweep = 0;
      end else if (sweep == N) sweep = -1;
      else sweep++;
      m_ov = ov_next;
   endtask

   // Single compare process: every negedge, all outputs against the model
   always @(negedge i_clk) begin : cmp
      logic [N*OUT_W-1:0] ex, ey;
      logic [N-1:0]       ez, ea;
      for (int k = 0; k < N; k++) begin
         ex[k*OUT_W +: OUT_W] = OUT_W'(mx[k] >>> OSH);
         ey[k*OUT_W +: OUT_W] = OUT_W'((my[k] + (mz[k] >>> 1)) >>> OSH);
         ez[k] = (mph[k] == 2);
         ea[k] = (mph[k] != 0);
      end
      check("x_pos", 64'(o_x_pos), 64'(ex));
      check("y_pos", 64'(o_y_pos), 64'(ey));
      check("z_neg", 64'(o_z_neg), 64'(ez));
      check("active", 64'(o_active), 64'(ea));
      check("busy", 64'(o_busy), 64'(sweep >= 0));
      check("frame_done", 64'(o_frame_done), 64'(sweep == N));
      check("overrun", 64'(o_overrun), 64'(m_ov));
   end

   task automatic tick();
      @(posedge i_clk);
      if (!i_rst_n) m_reset();
      else m_step();
      #1;
   endtask

   task automatic launch(input int id, input int vx, input int vy, input int vz);
      i_launch = 1'b1; i_launch_id = 2'(id);
      i_vx = 16'(vx); i_vy = 16'(vy); i_vz = 16'(vz);
      tick();
      i_launch = 1'b0;
   endtask

   task automatic run_frame();
      int n;
      i_refresh = 1'b1;
      tick();
      i_refresh = 1'b0;
      n = 0;
      while (!o_frame_done && n < 20) begin
         tick();
         n++;
      end
      check("frame_done_seen", 64'(o_frame_done), 64'd1);
      tick();
   endtask

   function automatic logic [OUT_W-1:0] fx(input int k);
      return o_x_pos[k*OUT_W +: OUT_W];
   endfunction

   function automatic logic [OUT_W-1:0] fy(input int k);
      return o_y_pos[k*OUT_W +: OUT_W];
   endfunction

   initial begin
      int n, fd_cnt, fd_at;
      i_rst_n = 1'b0; i_refresh = 1'b0; i_launch = 1'b0; i_launch_id = '0;
      i_vx = '0; i_vy = '0; i_vz = '0; i_en_collision = '0; i_collision_done = '0;
      m_reset();
      repeat (3) tick();
      i_rst_n = 1'b1;
      tick();

      // Reset in the middle of a sweep
      i_refresh = 1'b1; tick(); i_refresh = 1'b0;
      tick(); tick();
      #2 i_rst_n = 1'b0;
      m_reset();
      #1;
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_pos", 64'(o_x_pos | o_y_pos), 64'd0);
      check("rst_flags", 64'({o_z_neg, o_active, o_frame_done, o_overrun}), 64'd0);
      tick();
      i_rst_n = 1'b1;
      fd_cnt = 0;
      repeat (8) begin tick(); fd_cnt += int'(o_frame_done); end
      check("rst_no_frame_done", 64'(fd_cnt), 64'd0);

      // Basic launch and one frame
      launch(0, 8, 4, 9);
      i_refresh = 1'b1; tick(); i_refresh = 1'b0;
      n = 1;
      while (!o_frame_done && n < 20) begin tick(); n++; end
      check("frame_done_latency", 64'(n), 64'd5);
      tick();
      check("b0_x", 64'(fx(0)), 64'd2);
      check("b0_y", 64'(fy(0)), 64'd2);
      check("others_zero", 64'({o_x_pos[N*OUT_W-1:OUT_W], o_y_pos[N*OUT_W-1:OUT_W]}), 64'd0);
      i_collision_done = 4'b0001; tick(); i_collision_done = '0;

      // One bounce then landing at z = -6
      launch(0, 0, 0, 3);
      for (int f = 1; f <= 8; f++) begin
         run_frame();
         if (f < 8) begin
            check("bounce_not_landed", 64'(o_z_neg[0]), 64'd0);
            check("bounce_y", 64'(fy(0)), 64'd0);
         end
      end
      check("landed", 64'(o_z_neg[0]), 64'd1);
      check("landed_y", 64'(fy(0)), 64'h1fff);

      // Auto-clear after the settle period
      for (int f = 1; f <= SETTLE; f++) run_frame();
      check("settle_hold_active", 64'(o_active[0]), 64'd1);
      check("settle_hold_y", 64'(fy(0)), 64'h1fff);
      run_frame();
      check("settle_cleared", 64'(o_active[0]), 64'd0);

      // Held indefinitely while collision is enabled
      launch(0, 0, 0, 3);
      i_en_collision = 4'b0001;
      for (int f = 1; f <= 8 + SETTLE + 10; f++) run_frame();
      check("held_active", 64'(o_active[0]), 64'd1);
      check("held_z_neg", 64'(o_z_neg[0]), 64'd1);
      i_collision_done = 4'b0001; tick(); i_collision_done = '0;
      check("coll_done_clear", 64'(o_active[0]), 64'd0);
      i_en_collision = '0;

      // Overrun: refresh at t and t+2
      i_refresh = 1'b1; tick(); i_refresh = 1'b0;
      tick();
      i_refresh = 1'b1; tick(); i_refresh = 1'b0;
      check("overrun_pulse", 64'(o_overrun), 64'd1);
      fd_cnt = 0; fd_at = 0;
      for (int c = 4; c < 12; c++) begin
         tick();
         if (o_frame_done) begin fd_cnt++; fd_at = c; end
      end
      check("overrun_one_done", 64'(fd_cnt), 64'd1);
      check("overrun_done_at", 64'(fd_at), 64'd5);

      // Launch wins over clear and sweep update on the same slot
      launch(2, 10, 10, 20);
      run_frame();
      i_refresh = 1'b1; tick(); i_refresh = 1'b0;
      tick(); tick();
      i_launch = 1'b1; i_launch_id = 2'd2; i_vx = 16'sd5; i_vy = 16'sd6; i_vz = 16'sd7;
      i_collision_done = 4'b0100;
      tick();
      i_launch = 1'b0; i_collision_done = '0;
      check("relaunch_x", 64'(fx(2)), 64'd0);
      check("relaunch_y", 64'(fy(2)), 64'd0);
      check("relaunch_active", 64'(o_active[2]), 64'd1);
      repeat (4) tick();
      run_frame();
      check("relaunch_fx", 64'(fx(2)), 64'd1);
      check("relaunch_fy", 64'(fy(2)), 64'd2);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         i_refresh = ($urandom_range(7, 0) == 0);
         i_launch = ($urandom_range(5, 0) == 0);
         i_launch_id = 2'($urandom_range(3, 0));
         i_vx = 16'(int'($urandom_range(80, 0)) - 40);
         i_vy = 16'(int'($urandom_range(80, 0)) - 40);
         i_vz = 16'(int'($urandom_range(60, 0)) - 20);
         for (int k = 0; k < N; k++) i_collision_done[k] = ($urandom_range(63, 0) == 0);
         if ($urandom_range(99, 0) == 0) i_en_collision = 4'($urandom_range(15, 0));
         tick();
      end
      i_refresh = 1'b0; i_launch = 1'b0; i_collision_done = '0;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
